io_out_buffer: RTL and testbench

IO_OUT_BUFFER -- requirements
Module: io_out_buffer

---
 rtl/io_buffer_pkg.sv | 23 ++
 rtl/io_out_buffer_mem.sv | 37 +++
 rtl/io_out_buffer.sv | 124 ++++++++++++
 tb/tb_io_out_buffer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/io_buffer_pkg.sv
// ============================================================================
//  io_buffer_pkg
//  Shared sizing helpers and constants for the CPU I/O buffers.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package io_buffer_pkg;

  localparam int c_OVF_CNT_WIDTH = 16;

  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

  // One extra bit so that a completely full buffer (count == depth) is representable.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/io_out_buffer_mem.sv
// ============================================================================
//  io_out_buffer_mem
//  Simple dual-port RAM: one synchronous write port, one synchronous read port.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module io_out_buffer_mem
  import io_buffer_pkg::*;
#(
  parameter int WORD_WIDTH = 36,
  parameter int DEPTH      = 16
) (
  input  logic                        clk_i,
  input  logic                        wr_en_i,
  input  logic [ptr_width(DEPTH)-1:0] wr_addr_i,
  input  logic [WORD_WIDTH-1:0]       wr_data_i,
  input  logic [ptr_width(DEPTH)-1:0] rd_addr_i,
  output logic [WORD_WIDTH-1:0]       rd_data_o
);

  logic [WORD_WIDTH-1:0] mem_q [DEPTH];
  logic [WORD_WIDTH-1:0] rd_data_q;

  // No reset on storage or read register so the array maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

`default_nettype wire

// File: rtl/io_out_buffer.sv
// ============================================================================
//  io_out_buffer
//  CPU write-port FIFO with early-full flag and registered head-word output.
//  Optional: IO_OUT_BUFFER_OVERFLOW_COUNT_EN adds a saturating drop counter.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module io_out_buffer
  import io_buffer_pkg::*;
#(
  parameter int WORD_WIDTH = 36,
  parameter int DEPTH      = 16,
  parameter int EF_MARGIN  = 8
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        io_wren,
  input  logic [WORD_WIDTH-1:0]       io_out,
  output logic                        io_out_EF,
  output logic                        out_valid,
  output logic [WORD_WIDTH-1:0]       out_data,
  input  logic                        out_ready,
`ifdef IO_OUT_BUFFER_OVERFLOW_COUNT_EN
  output logic [cnt_width(DEPTH)-1:0] count,
  output logic [c_OVF_CNT_WIDTH-1:0]  overflow_count
`else
  output logic [cnt_width(DEPTH)-1:0] count
`endif
);

  localparam int c_PW = ptr_width(DEPTH);
  localparam int c_CW = cnt_width(DEPTH);
  localparam logic [c_CW-1:0] c_FULL  = c_CW'(DEPTH);
  localparam logic [c_CW-1:0] c_EF_TH = c_CW'(DEPTH - EF_MARGIN);

  logic [c_PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [c_CW-1:0]       count_q, count_d, w_remain;
  logic                  out_valid_q, out_valid_d;
  logic                  fwd_q, fwd_d;
  logic                  ef_q;
  logic [WORD_WIDTH-1:0] fwd_data_q, w_mem_rdata;
  logic                  w_full, w_push, w_pop;

  assign w_full = (count_q == c_FULL);
  assign w_push = io_wren && !w_full;
  assign w_pop  = out_valid_q && out_ready;

  always_comb begin
    wr_ptr_d    = wr_ptr_q + c_PW'(w_push);
    rd_ptr_d    = rd_ptr_q + c_PW'(w_pop);
    w_remain    = count_q - c_CW'(w_pop);
    count_d     = w_remain + c_CW'(w_push);
    out_valid_d = 1'b0;
    fwd_d       = 1'b0;
    // Words already in RAM are fetched by the sync read; a word written in the
    // same cycle the last word leaves is forwarded past the RAM instead.
    if (w_remain != '0) begin
      out_valid_d = 1'b1;
    end else if (w_push && w_pop) begin
      out_valid_d = 1'b1;
      fwd_d       = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      fwd_q       <= 1'b0;
      fwd_data_q  <= '0;
      ef_q        <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      fwd_q       <= fwd_d;
      if (fwd_d) begin
        fwd_data_q <= io_out;
      end
      ef_q        <= (count_d >= c_EF_TH);
    end
  end

  io_out_buffer_mem #(
    .WORD_WIDTH (WORD_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk_i     (clock),
    .wr_en_i   (w_push),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (io_out),
    .rd_addr_i (rd_ptr_d),
    .rd_data_o (w_mem_rdata)
  );

  // The RAM read register has no reset, so the output is masked while invalid.
  assign out_data  = out_valid_q ? (fwd_q ? fwd_data_q : w_mem_rdata) : '0;
  assign out_valid = out_valid_q;
  assign io_out_EF = ef_q;
  assign count     = count_q;

`ifdef IO_OUT_BUFFER_OVERFLOW_COUNT_EN
  logic [c_OVF_CNT_WIDTH-1:0] ovf_cnt_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ovf_cnt_q <= '0;
    end else if (io_wren && w_full && (ovf_cnt_q != '1)) begin
      ovf_cnt_q <= ovf_cnt_q + 1'b1;
    end
  end

  assign overflow_count = ovf_cnt_q;
`else
  // Dropped writes are discarded silently when no counter is built.
`endif

endmodule

`default_nettype wire

// File: tb/tb_io_out_buffer.sv
// ============================================================================
//  tb_io_out_buffer
//  Randomised self-checking bench for io_out_buffer against a queue model.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_io_out_buffer;

  localparam int W = 36;
  localparam int D = 16;
  localparam int M = 8;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         io_wren = 1'b0;
  logic [W-1:0] io_out = '0;
  logic         out_ready = 1'b0;
  logic         io_out_EF;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [4:0]   count;
`ifdef IO_OUT_BUFFER_OVERFLOW_COUNT_EN
  logic [15:0]  overflow_count;
`endif

  io_out_buffer #(
    .WORD_WIDTH (W),
    .DEPTH      (D),
    .EF_MARGIN  (M)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .io_wren        (io_wren),
    .io_out         (io_out),
    .io_out_EF      (io_out_EF),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_ready      (out_ready),
`ifdef IO_OUT_BUFFER_OVERFLOW_COUNT_EN
    .count          (count),
    .overflow_count (overflow_count)
`else
    .count          (count)
`endif
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: the words in the buffer, the edge each arrived on.
  logic [W-1:0] md[$];
  int           mage[$];
  int           ecnt = 0;
  logic         m_valid = 1'b0;
  int           m_ovf = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    md.delete();
    mage.delete();
    m_valid = 1'b0;
    m_ovf   = 0;
  endtask

  task automatic model_edge(input logic wr, input logic [W-1:0] d, input logic rdy);
    bit full;
    bit pop;
    full = (md.size() == D);
    pop  = m_valid && rdy;
    ecnt++;
    if (pop) begin
      void'(md.pop_front());
      void'(mage.pop_front());
    end
    if (wr && !full) begin
      md.push_back(d);
      mage.push_back(ecnt);
    end
    if (wr && full && m_ovf < 65535) m_ovf++;
    // A word is presentable once it has sat in the buffer across an edge,
    // or immediately when it replaces the sole word popped on the same edge.
    m_valid = (md.size() != 0) && ((mage[0] < ecnt) || pop);
  endtask

  task automatic check_all();
    check_eq("count", 64'(count), 64'(md.size()));
    check_eq("out_valid", 64'(out_valid), 64'(m_valid));
    check_eq("io_out_EF", 64'(io_out_EF), 64'(md.size() >= D - M));
    if (m_valid) check_eq("out_data", 64'(out_data), 64'(md[0]));
`ifdef IO_OUT_BUFFER_OVERFLOW_COUNT_EN
    check_eq("overflow_count", 64'(overflow_count), 64'(m_ovf));
`endif
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input logic wr, input logic [W-1:0] d, input logic rdy);
    io_wren   = wr;
    io_out    = d;
    out_ready = rdy;
    @(posedge clock);
    model_edge(wr, d, rdy);
    #1;
    check_all();
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    io_wren = 1'b0;
    out_ready = 1'b0;
    model_clear();
    #1;
    check_eq("rst_count", 64'(count), 64'd0);
    check_eq("rst_valid", 64'(out_valid), 64'd0);
    check_eq("rst_ef", 64'(io_out_EF), 64'd0);
    check_eq("rst_data", 64'(out_data), 64'd0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    int sent;
    logic wr;

    repeat (2) @(posedge clock);
    @(negedge clock);
    do_reset();

    // Single write into empty buffer.
    step(1'b1, W'(36'h000000123), 1'b0);
    step(1'b0, '0, 1'b0);
    check_eq("first_word", 64'(out_data), 64'h123);

    // Fill to the early-full threshold, then to full, then one dropped write.
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, W'(36'h100 + i), 1'b0);
    check_eq("ef_at_8", 64'(io_out_EF), 64'd1);
    for (int i = 8; i < 16; i++) step(1'b1, W'(36'h100 + i), 1'b0);
    check_eq("full_count", 64'(count), 64'd16);
    step(1'b1, W'(36'hBAD), 1'b0);

    // Full: a write and a pop on the same edge; the write is dropped.
    step(1'b1, W'(36'hDEAD), 1'b1);
    check_eq("full_pushpop_count", 64'(count), 64'd15);
    check_eq("full_pushpop_head", 64'(out_data), 64'h101);

    // Drain to one word, then push and pop together.
    for (int c = 0; c < 64 && md.size() > 1; c++) step(1'b0, '0, 1'b1);
    step(1'b1, W'(36'h5A5A5), 1'b1);
    check_eq("one_pushpop_count", 64'(count), 64'd1);
    check_eq("one_pushpop_data", 64'(out_data), 64'h5A5A5);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b1);

    // Stream 40 sequential words with random back-pressure.
    do_reset();
    sent = 0;
    for (int c = 0; c < 2000 && (sent < 40 || md.size() != 0); c++) begin
      wr = (sent < 40) && (md.size() < D) && ($urandom_range(0, 3) != 0);
      step(wr, W'(36'h200 + sent), 1'($urandom_range(0, 1)));
      if (wr) sent++;
    end
    check_eq("stream_drained", 64'(count), 64'd0);

    // Reset with five words buffered.
    for (int i = 0; i < 5; i++) step(1'b1, W'(36'h300 + i), 1'b0);
    do_reset();
    step(1'b1, W'(36'hABC), 1'b0);
    step(1'b0, '0, 1'b0);
    check_eq("post_reset_first", 64'(out_data), 64'hABC);

    // Random traffic including overflow.
    for (int c = 0; c < 400; c++) begin
      step(1'($urandom_range(0, 3) != 0), W'({$urandom(), $urandom()}),
           1'($urandom_range(0, 2) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
